// File: rtl/asip_hazard_pkg.sv
// Shared types for the ASIP hazard controller: the in-flight write tag and the controller state.
// Both register files are 16 entries deep, so the register index is 4 bits.
package asip_hazard_pkg;
   localparam int RW = 4;
   localparam logic [RW-1:0] SCALAR_ZERO = '0;

   typedef struct packed {
      logic          vld;
      logic          vec;
      logic [RW-1:0] rd;
   } hzd_tag_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      RAW    = 2'd1,
      FLUSH  = 2'd2,
      FREEZE = 2'd3
   } hzd_state_t;

   // A write to scalar r0 is dropped when r0 is hardwired, so it can never create a hazard.
   function automatic hzd_tag_t make_tag(input logic we, input logic vec,
                                         input logic [RW-1:0] rd, input logic zero_hw);
      hzd_tag_t t;
      t.vec = vec;
      t.rd  = rd;
      t.vld = we & ~(zero_hw & ~vec & (rd == SCALAR_ZERO));
      return t;
   endfunction
endpackage

// File: rtl/hazard_src_cmp.sv
// Compares one ID source operand against the EX/MEM/WB write tags.
// Register file and index must both match; scalar k and vector k are different registers.
module hazard_src_cmp
   import asip_hazard_pkg::*;
(
   input  logic          i_src_vld,
   input  logic          i_src_vec,
   input  logic [RW-1:0] i_src,
   input  hzd_tag_t      i_ex_tag,
   input  hzd_tag_t      i_mem_tag,
   input  hzd_tag_t      i_wb_tag,
   output logic          o_match
);
   hzd_tag_t   w_tags [3];
   logic [2:0] w_hit;

   assign w_tags[0] = i_ex_tag;
   assign w_tags[1] = i_mem_tag;
   assign w_tags[2] = i_wb_tag;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_slot
         assign w_hit[gi] = w_tags[gi].vld && (w_tags[gi].vec == i_src_vec)
                            && (w_tags[gi].rd == i_src);
      end
   endgenerate

   assign o_match = i_src_vld & (|w_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW-stall / flush / freeze controller for the 5-stage scalar+vector ASIP pipeline.
// Keeps a shadow of in-flight destination tags and drives the PC and segment register controls.
module pipeline_hazard_ctrl
   import asip_hazard_pkg::*;
#(
   parameter int NSRC    = 3,
   parameter bit ZERO_HW = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid_i,
   input  logic [NSRC*RW-1:0] id_src_i,
   input  logic [NSRC-1:0]    id_src_vld_i,
   input  logic [NSRC-1:0]    id_src_vec_i,
   input  logic [RW-1:0]      id_rd_i,
   input  logic               id_rd_we_i,
   input  logic               id_rd_vec_i,
   input  logic               pcsrc_ex_i,
   input  logic               mem_busy_i,
   output logic               pc_load_o,
   output logic               if_id_load_o,
   output logic               if_id_clr_o,
   output logic               id_ex_load_o,
   output logic               id_ex_clr_o,
   output logic               ex_mem_load_o,
   output logic               mem_wb_load_o,
   output logic [1:0]         state_o,
   output logic [CNT_W-1:0]   stall_cnt_o,
   output logic [CNT_W-1:0]   flush_cnt_o
);
   hzd_tag_t         r_ex_tag, r_mem_tag, r_wb_tag;
   hzd_state_t       r_state;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   hzd_tag_t         w_id_tag;
   logic [NSRC-1:0]  w_src_match;
   logic             w_hazard;
   hzd_state_t       w_next_state;

   assign w_id_tag = make_tag(id_rd_we_i, id_rd_vec_i, id_rd_i, ZERO_HW);

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         hazard_src_cmp u_cmp (
            .i_src_vld (id_src_vld_i[gi]),
            .i_src_vec (id_src_vec_i[gi]),
            .i_src     (id_src_i[gi*RW +: RW]),
            .i_ex_tag  (r_ex_tag),
            .i_mem_tag (r_mem_tag),
            .i_wb_tag  (r_wb_tag),
            .o_match   (w_src_match[gi])
         );
      end
   endgenerate

   // The WB slot is included: ID reads the file before the WB write lands at the edge.
   assign w_hazard = id_valid_i & (|w_src_match);

   always_comb begin
      if (mem_busy_i)      w_next_state = FREEZE;
      else if (pcsrc_ex_i) w_next_state = FLUSH;
      else if (w_hazard)   w_next_state = RAW;
      else                 w_next_state = RUN;
   end

   always_comb begin
      pc_load_o     = 1'b1;
      if_id_load_o  = 1'b1;
      if_id_clr_o   = 1'b0;
      id_ex_load_o  = 1'b1;
      id_ex_clr_o   = 1'b0;
      ex_mem_load_o = 1'b1;
      mem_wb_load_o = 1'b1;
      if (rst) begin
         pc_load_o     = 1'b0;
         if_id_load_o  = 1'b0;
         id_ex_load_o  = 1'b0;
         ex_mem_load_o = 1'b0;
         mem_wb_load_o = 1'b0;
         if_id_clr_o   = 1'b1;
         id_ex_clr_o   = 1'b1;
      end else begin
         case (w_next_state)
            FREEZE: begin
               pc_load_o     = 1'b0;
               if_id_load_o  = 1'b0;
               id_ex_load_o  = 1'b0;
               ex_mem_load_o = 1'b0;
               mem_wb_load_o = 1'b0;
            end
            FLUSH: begin
               if_id_clr_o = 1'b1;
               id_ex_clr_o = 1'b1;
            end
            RAW: begin
               pc_load_o    = 1'b0;
               if_id_load_o = 1'b0;
               id_ex_clr_o  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_tag    <= '0;
         r_mem_tag   <= '0;
         r_wb_tag    <= '0;
         r_state     <= RUN;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (!mem_busy_i) begin
            r_wb_tag  <= r_mem_tag;
            r_mem_tag <= r_ex_tag;
            // Only an instruction actually issued in RUN enters EX; bubbles and flushes leave it empty.
            r_ex_tag  <= (w_next_state == RUN && id_valid_i) ? w_id_tag : '0;
         end
         if (w_next_state == RAW && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_next_state == FLUSH && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign state_o     = r_state;
   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (r0 hardwired / 16-bit counters, and r0 tracked / 4-bit
// counters) share one stimulus; a per-register countdown model checks both every cycle.
module tb_pipeline_hazard_ctrl;
   localparam int NSRC = 3;
   localparam int RW   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic               id_valid, id_rd_we, id_rd_vec, pcsrc, busy;
   logic [NSRC*RW-1:0] id_src;
   logic [NSRC-1:0]    src_vld, src_vec;
   logic [RW-1:0]      id_rd;

   logic        pc_load [2], if_id_load [2], if_id_clr [2], id_ex_load [2], id_ex_clr [2];
   logic        ex_mem_load [2], mem_wb_load [2];
   logic [1:0]  st [2];
   logic [15:0] stall_cnt0, flush_cnt0;
   logic [3:0]  stall_cnt1, flush_cnt1;

   pipeline_hazard_ctrl #(.NSRC(3), .ZERO_HW(1'b1), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_src_i(id_src), .id_src_vld_i(src_vld),
      .id_src_vec_i(src_vec), .id_rd_i(id_rd), .id_rd_we_i(id_rd_we), .id_rd_vec_i(id_rd_vec),
      .pcsrc_ex_i(pcsrc), .mem_busy_i(busy), .pc_load_o(pc_load[0]), .if_id_load_o(if_id_load[0]),
      .if_id_clr_o(if_id_clr[0]), .id_ex_load_o(id_ex_load[0]), .id_ex_clr_o(id_ex_clr[0]),
      .ex_mem_load_o(ex_mem_load[0]), .mem_wb_load_o(mem_wb_load[0]), .state_o(st[0]),
      .stall_cnt_o(stall_cnt0), .flush_cnt_o(flush_cnt0));

   pipeline_hazard_ctrl #(.NSRC(3), .ZERO_HW(1'b0), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_src_i(id_src), .id_src_vld_i(src_vld),
      .id_src_vec_i(src_vec), .id_rd_i(id_rd), .id_rd_we_i(id_rd_we), .id_rd_vec_i(id_rd_vec),
      .pcsrc_ex_i(pcsrc), .mem_busy_i(busy), .pc_load_o(pc_load[1]), .if_id_load_o(if_id_load[1]),
      .if_id_clr_o(if_id_clr[1]), .id_ex_load_o(id_ex_load[1]), .id_ex_clr_o(id_ex_clr[1]),
      .ex_mem_load_o(ex_mem_load[1]), .mem_wb_load_o(mem_wb_load[1]), .state_o(st[1]),
      .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1));

   int n_checks = 0;
   int n_fail   = 0;
   bit done     = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] outs(input int k);
      return {pc_load[k], if_id_load[k], if_id_clr[k], id_ex_load[k], id_ex_clr[k],
              ex_mem_load[k], mem_wb_load[k]};
   endfunction

   function automatic longint stall_of(input int k);
      return (k == 0) ? longint'(stall_cnt0) : longint'(stall_cnt1);
   endfunction

   function automatic longint flush_of(input int k);
      return (k == 0) ? longint'(flush_cnt0) : longint'(flush_cnt1);
   endfunction

   // Model: pend[k][file][reg] = unfrozen cycles until that register's write has retired.
   int   pend [2][2][16];
   int   m_state [2], m_stall [2], m_flush [2];
   int   sat [2]   = '{65535, 15};
   bit   zhw [2]   = '{1'b1, 1'b0};
   bit   hz;
   int   dec;
   logic [6:0] exp_ctl;

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_state[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
         for (int f = 0; f < 2; f++) for (int r = 0; r < 16; r++) pend[k][f][r] = 0;
      end
   end

   always @(negedge clk) begin
      if (!done) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_state", k), st[k], m_state[k]);
            chk($sformatf("d%0d_stall_cnt", k), stall_of(k), m_stall[k]);
            chk($sformatf("d%0d_flush_cnt", k), flush_of(k), m_flush[k]);
            hz = 1'b0;
            for (int s = 0; s < NSRC; s++)
               if (id_valid && src_vld[s] && pend[k][src_vec[s]][id_src[s*RW +: RW]] > 0) hz = 1'b1;
            dec = busy ? 3 : pcsrc ? 2 : hz ? 1 : 0;
            if (rst)           exp_ctl = 7'b0010100;
            else if (dec == 3) exp_ctl = 7'b0000000;
            else if (dec == 2) exp_ctl = 7'b1111111;
            else if (dec == 1) exp_ctl = 7'b0001111;
            else               exp_ctl = 7'b1101011;
            chk($sformatf("d%0d_ctrl", k), outs(k), exp_ctl);
            if (rst) begin
               m_state[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
               for (int f = 0; f < 2; f++) for (int r = 0; r < 16; r++) pend[k][f][r] = 0;
            end else begin
               m_state[k] = dec;
               if (dec == 1 && m_stall[k] < sat[k]) m_stall[k]++;
               if (dec == 2 && m_flush[k] < sat[k]) m_flush[k]++;
               if (!busy) begin
                  for (int f = 0; f < 2; f++)
                     for (int r = 0; r < 16; r++) if (pend[k][f][r] > 0) pend[k][f][r]--;
                  if (dec == 0 && id_valid && id_rd_we && !(zhw[k] && !id_rd_vec && id_rd == 0))
                     pend[k][id_rd_vec][id_rd] = 3;
               end
            end
         end
      end
   end

   task automatic drive_idle();
      id_valid = 0; id_rd_we = 0; id_rd_vec = 0; id_rd = '0;
      id_src = '0; src_vld = '0; src_vec = '0; pcsrc = 0; busy = 0;
   endtask

   task automatic idle(input int n);
      drive_idle();
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drive_prod(input logic vec, input logic [3:0] rd);
      drive_idle();
      id_valid = 1; id_rd_we = 1; id_rd_vec = vec; id_rd = rd;
   endtask

   task automatic drive_cons(input logic vec, input logic [3:0] rs);
      drive_idle();
      id_valid = 1; id_src[RW-1:0] = rs; src_vld = 3'b001; src_vec = {2'b00, vec};
   endtask

   // Hold the current ID instruction until instance k issues it; count RAW cycles seen meanwhile.
   task automatic run_until_accept(input int k, output int raws);
      bit acc;
      raws = 0; acc = 0;
      for (int c = 0; c < 20 && !acc; c++) begin
         @(negedge clk); #1;
         if (id_ex_load[k] && !id_ex_clr[k]) acc = 1;
         else if (!pc_load[k] && id_ex_clr[k]) raws++;
         @(posedge clk); #1;
      end
      chk($sformatf("d%0d_accepted", k), acc, 1);
   endtask

   int r, r0, r1, s_base, f_base;

   initial begin
      drive_idle();
      rst = 1;
      @(negedge clk); #1;
      chk("rst_ctrl", outs(0), 7'b0010100);
      repeat (2) @(posedge clk); #1;
      rst = 0;

      // 1: scalar back-to-back RAW
      drive_prod(0, 4'd3); run_until_accept(0, r); chk("t1_prod_raws", r, 0);
      drive_cons(0, 4'd3); run_until_accept(0, r); chk("t1_raws", r, 3);
      chk("t1_stall_cnt", stall_cnt0, 3);

      // 2: vector write vs scalar/vector read
      idle(3);
      drive_prod(1, 4'd2); run_until_accept(0, r);
      drive_cons(0, 4'd2); run_until_accept(0, r); chk("t2_scalar_raws", r, 0);
      idle(3);
      drive_prod(1, 4'd2); run_until_accept(0, r);
      drive_cons(1, 4'd2); run_until_accept(0, r); chk("t2_vector_raws", r, 3);

      // 3: r0 hardwired in dut0, tracked in dut1
      idle(3);
      drive_prod(0, 4'd0); run_until_accept(0, r);
      drive_cons(0, 4'd0);
      r0 = 0; r1 = 0;
      repeat (4) begin
         @(negedge clk); #1;
         if (!pc_load[0] && id_ex_clr[0]) r0++;
         if (!pc_load[1] && id_ex_clr[1]) r1++;
         @(posedge clk); #1;
      end
      chk("t3_zero_hw1_raws", r0, 0);
      chk("t3_zero_hw0_raws", r1, 3);

      // 4: taken branch overrides RAW
      idle(3);
      s_base = stall_cnt0;
      drive_prod(0, 4'd5); run_until_accept(0, r);
      drive_cons(0, 4'd5); pcsrc = 1;
      @(negedge clk); #1;
      chk("t4_if_id_clr", if_id_clr[0], 1);
      chk("t4_id_ex_clr", id_ex_clr[0], 1);
      chk("t4_pc_load", pc_load[0], 1);
      @(posedge clk); #1;
      drive_idle();
      chk("t4_flush_cnt", flush_cnt0, 1);
      chk("t4_stall_cnt", stall_cnt0, s_base);

      // 5: freeze in the middle of a RAW
      idle(3);
      s_base = stall_cnt0;
      drive_prod(0, 4'd7); run_until_accept(0, r);
      drive_cons(0, 4'd7);
      @(negedge clk); #1;
      chk("t5_first_raw", {pc_load[0], id_ex_clr[0]}, 2'b01);
      @(posedge clk); #1;
      busy = 1;
      repeat (4) begin
         @(negedge clk); #1;
         chk("t5_frozen_loads", {pc_load[0], if_id_load[0], id_ex_load[0], ex_mem_load[0],
                                 mem_wb_load[0]}, 0);
         @(posedge clk); #1;
      end
      busy = 0;
      run_until_accept(0, r); chk("t5_remaining_raws", r, 2);
      chk("t5_stall_total", stall_cnt0, s_base + 3);

      // saturation of the 4-bit counters in dut1
      idle(3);
      s_base = stall_cnt0;
      for (int i = 0; i < 6; i++) begin
         drive_prod(0, 4'd1); run_until_accept(0, r);
         drive_cons(0, 4'd1); run_until_accept(0, r);
      end
      chk("sat_dut1_stall", stall_cnt1, 15);
      chk("sat_dut0_stall", stall_cnt0, s_base + 18);

      // 6: reset during RAW
      drive_prod(0, 4'd9); run_until_accept(0, r);
      drive_cons(0, 4'd9);
      @(negedge clk); #1;
      chk("t6_raw_before_rst", id_ex_clr[0], 1);
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk); #1;
      chk("t6_rst_ctrl", outs(0), 7'b0010100);
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk); #1;
      chk("t6_no_hazard_after_rst", {pc_load[0], id_ex_clr[0]}, 2'b10);
      chk("t6_state", st[0], 0);
      chk("t6_stall_cnt", stall_cnt0, 0);
      chk("t6_flush_cnt", flush_cnt0, 0);
      @(posedge clk); #1;

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         id_valid  = ($urandom_range(0, 3) != 0);
         id_rd_we  = $urandom_range(0, 1);
         id_rd_vec = $urandom_range(0, 1);
         id_rd     = 4'($urandom_range(0, 3));
         for (int s = 0; s < NSRC; s++) id_src[s*RW +: RW] = 4'($urandom_range(0, 3));
         src_vld   = 3'($urandom_range(0, 7));
         src_vec   = 3'($urandom_range(0, 7));
         pcsrc     = ($urandom_range(0, 7) == 0);
         busy      = ($urandom_range(0, 5) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         @(posedge clk); #1;
      end
      rst = 0;
      drive_idle();
      @(posedge clk); #1;
      done = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
